// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned multiply/divide controller that borrows the execute-stage ALU.
// Shift-add multiply and restoring divide, one ALU operation per cycle, 32 steps.
`timescale 1ns/1ps
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             alu_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_control
);

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] opnd;
    logic             op_r;
    logic [5:0]       count;
    logic [WIDTH-1:0] rem;
    logic             msb;
    logic             carry;
    logic             quot;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A zero divisor has a fixed answer, so it bypasses RUN entirely.
    always_comb begin
        state_next  = state;
        busy        = 1'b0;
        done        = 1'b0;
        alu_sel     = 1'b0;
        alu_a       = '0;
        alu_b       = '0;
        alu_control = ALU_ADD;
        rem         = {hi[WIDTH-2:0], lo[WIDTH-1]};
        msb         = hi[WIDTH-1];
        carry       = 1'b0;
        quot        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (op && src_b == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                alu_sel = 1'b1;
                if (op_r) begin
                    alu_a       = rem;
                    alu_b       = opnd;
                    alu_control = ALU_SUB;
                    quot        = msb | (rem >= opnd);
                end else begin
                    alu_a       = hi;
                    alu_b       = lo[0] ? opnd : '0;
                    alu_control = ALU_ADD;
                    carry       = (alu_result < hi);
                end
                if (count == 6'd31) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The ALU add drops its carry-out, so it is recovered by comparing the sum with hi.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi    <= '0;
            lo    <= '0;
            opnd  <= '0;
            op_r  <= 1'b0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r  <= op;
                        count <= '0;
                        hi    <= '0;
                        if (op) begin
                            lo   <= src_a;
                            opnd <= src_b;
                            if (src_b == '0) begin
                                hi <= src_a;
                                lo <= '1;
                            end
                        end else begin
                            lo   <= src_b;
                            opnd <= src_a;
                        end
                    end
                end
                RUN: begin
                    count <= count + 6'd1;
                    if (op_r) begin
                        hi <= quot ? alu_result : rem;
                        lo <= {lo[WIDTH-2:0], quot};
                    end else begin
                        {hi, lo} <= {carry, alu_result, lo[WIDTH-1:1]};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: models the ALU and scores results
// against a queue of expected {hi, lo} values pushed as each operation is started.
`timescale 1ns/1ps
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] alu_result;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        alu_sel;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_control;

    int          tests_run = 0;
    int          tests_failed = 0;
    int          sel_cnt = 0;
    int          done_cnt = 0;
    logic [63:0] exp_q[$];

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .op(op),
        .src_a(src_a),
        .src_b(src_b),
        .alu_result(alu_result),
        .busy(busy),
        .done(done),
        .hi(hi),
        .lo(lo),
        .alu_sel(alu_sel),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_control(alu_control)
    );

    always #5 clk = ~clk;

    // Stand-in for the execute-stage ALU.
    assign alu_result = (alu_control == 3'b110) ? (alu_a - alu_b) : (alu_a + alu_b);

    always @(negedge clk) begin
        if (alu_sel === 1'b1) sel_cnt++;
        if (done === 1'b1) done_cnt++;
    end

    // Drives one start cycle and records the reference result for it.
    task automatic applyStimulus(input logic o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] e;
        if (!o) e = {32'b0, a} * {32'b0, b};
        else if (b == 32'd0) e = {a, 32'hFFFFFFFF};
        else e = {a % b, a / b};
        exp_q.push_back(e);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(posedge clk); #1;
        start = 1'b0;
        op    = 1'($urandom_range(0, 1));
        src_a = $urandom;
        src_b = $urandom;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        src_a = '0;
        src_b = '0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags: busy=%b done=%b, expected 0 0", busy, done);
        end
        tests_run++;
        if (hi !== 32'd0 || lo !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_hilo: hi=%h lo=%h, expected 0 0", hi, lo);
        end
        tests_run++;
        if (alu_sel !== 1'b0 || alu_a !== 32'd0 || alu_b !== 32'd0 || alu_control !== 3'b010) begin
            tests_failed++;
            $display("[TB] FAIL reset_alu: sel=%b a=%h b=%h ctl=%b, expected 0 0 0 010",
                     alu_sel, alu_a, alu_b, alu_control);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_with_start();
        reset = 1'b1;
        start = 1'b1;
        op    = 1'b0;
        src_a = 32'd3;
        src_b = 32'd5;
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0 || lo !== 32'd0 || alu_sel !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_wins: busy=%b lo=%h alu_sel=%b, expected 0 0 0", busy, lo, alu_sel);
        end
    endtask

    task automatic test_multu();
        logic [31:0] ta[4];
        logic [31:0] tb_v[4];
        logic [63:0] e;
        int          lat;
        int          sel0;
        int          done0;
        ta   = '{32'd6, 32'hFFFFFFFF, 32'h0001_0000, 32'h89AB_CDEF};
        tb_v = '{32'd7, 32'hFFFFFFFF, 32'h0001_0000, 32'h1357_9BDF};
        for (int i = 0; i < 4; i++) begin
            sel0  = sel_cnt;
            done0 = done_cnt;
            applyStimulus(1'b0, ta[i], tb_v[i]);
            tests_run++;
            if (alu_sel !== 1'b1 || alu_control !== 3'b010) begin
                tests_failed++;
                $display("[TB] FAIL mul_alu_run[%0d]: sel=%b ctl=%b, expected 1 010", i, alu_sel, alu_control);
            end
            wait_done(lat);
            tests_run++;
            if (lat !== 32) begin
                tests_failed++;
                $display("[TB] FAIL mul_latency[%0d]: got %0d, expected 32", i, lat);
            end
            e = exp_q.pop_front();
            tests_run++;
            if ({hi, lo} !== e) begin
                tests_failed++;
                $display("[TB] FAIL mul_result[%0d]: got %h_%h, expected %h", i, hi, lo, e);
            end
            @(posedge clk); #1;
            tests_run++;
            if (done !== 1'b0 || busy !== 1'b0 || {hi, lo} !== e) begin
                tests_failed++;
                $display("[TB] FAIL mul_hold[%0d]: done=%b busy=%b hilo=%h_%h, expected 0 0 %h",
                         i, done, busy, hi, lo, e);
            end
            tests_run++;
            if (sel_cnt - sel0 !== 32 || done_cnt - done0 !== 1) begin
                tests_failed++;
                $display("[TB] FAIL mul_pulses[%0d]: alu_sel cycles=%0d done pulses=%0d, expected 32 1",
                         i, sel_cnt - sel0, done_cnt - done0);
            end
        end
    endtask

    task automatic test_divu();
        logic [31:0] ta[5];
        logic [31:0] tb_v[5];
        logic [63:0] e;
        int          lat;
        ta   = '{32'd100, 32'h8000_0000, 32'hFFFFFFFF, 32'hDEAD_BEEF, 32'd3};
        tb_v = '{32'd7,   32'd3,         32'hFFFFFFFF, 32'h0000_1234, 32'd10};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, ta[i], tb_v[i]);
            tests_run++;
            if (alu_sel !== 1'b1 || alu_control !== 3'b110) begin
                tests_failed++;
                $display("[TB] FAIL div_alu_run[%0d]: sel=%b ctl=%b, expected 1 110", i, alu_sel, alu_control);
            end
            wait_done(lat);
            tests_run++;
            if (lat !== 32) begin
                tests_failed++;
                $display("[TB] FAIL div_latency[%0d]: got %0d, expected 32", i, lat);
            end
            e = exp_q.pop_front();
            tests_run++;
            if ({hi, lo} !== e) begin
                tests_failed++;
                $display("[TB] FAIL div_result[%0d]: got hi=%h lo=%h, expected hi=%h lo=%h",
                         i, hi, lo, e[63:32], e[31:0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_div_zero();
        logic [63:0] e;
        int          lat;
        int          sel0;
        int          done0;
        sel0  = sel_cnt;
        done0 = done_cnt;
        applyStimulus(1'b1, 32'd5, 32'd0);
        wait_done(lat);
        tests_run++;
        if (lat !== 0) begin
            tests_failed++;
            $display("[TB] FAIL divzero_latency: got %0d, expected 0", lat);
        end
        e = exp_q.pop_front();
        tests_run++;
        if ({hi, lo} !== e || alu_sel !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL divzero_result: hi=%h lo=%h sel=%b, expected hi=%h lo=%h sel=0",
                     hi, lo, alu_sel, e[63:32], e[31:0]);
        end
        @(posedge clk); #1;
        tests_run++;
        if (busy !== 1'b0 || sel_cnt - sel0 !== 0 || done_cnt - done0 !== 1) begin
            tests_failed++;
            $display("[TB] FAIL divzero_after: busy=%b alu_sel cycles=%0d done pulses=%0d, expected 0 0 1",
                     busy, sel_cnt - sel0, done_cnt - done0);
        end
    endtask

    task automatic test_start_during_run();
        logic [63:0] e;
        int          lat;
        int          done0;
        done0 = done_cnt;
        applyStimulus(1'b0, 32'd6, 32'd7);
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1;
        op    = 1'b1;
        src_a = 32'd100;
        src_b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat);
        tests_run++;
        if (lat !== 26) begin
            tests_failed++;
            $display("[TB] FAIL ignore_latency: got %0d, expected 26", lat);
        end
        e = exp_q.pop_front();
        tests_run++;
        if ({hi, lo} !== e) begin
            tests_failed++;
            $display("[TB] FAIL ignore_result: got %h_%h, expected %h", hi, lo, e);
        end
        repeat (40) @(posedge clk);
        #1;
        tests_run++;
        if (done_cnt - done0 !== 1 || exp_q.size() !== 0) begin
            tests_failed++;
            $display("[TB] FAIL ignore_pulses: done pulses=%0d pending=%0d, expected 1 0",
                     done_cnt - done0, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_run();
        logic [63:0] e;
        int          lat;
        int          done0;
        done0 = done_cnt;
        applyStimulus(1'b0, 32'h0000_1234, 32'h0000_5678);
        exp_q.delete();
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || alu_sel !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_state: busy=%b hi=%h lo=%h sel=%b, expected 0 0 0 0",
                     busy, hi, lo, alu_sel);
        end
        repeat (40) @(posedge clk);
        #1;
        tests_run++;
        if (done_cnt - done0 !== 0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_done: done pulses=%0d, expected 0", done_cnt - done0);
        end
        applyStimulus(1'b0, 32'd3, 32'd5);
        wait_done(lat);
        e = exp_q.pop_front();
        tests_run++;
        if (lat !== 32 || {hi, lo} !== e) begin
            tests_failed++;
            $display("[TB] FAIL midreset_next: latency=%0d hilo=%h_%h, expected 32 %h", lat, hi, lo, e);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [63:0] e;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'(i % 2), $urandom, 32'h0000_FFFF & $urandom);
            wait_done(lat);
            e = exp_q.pop_front();
            tests_run++;
            if (lat !== ((i % 2 == 1 && src_b === 32'hx) ? 0 : lat) || {hi, lo} !== e) begin
                tests_failed++;
                $display("[TB] FAIL b2b_result[%0d]: latency=%0d hilo=%h_%h, expected %h", i, lat, hi, lo, e);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        src_a = '0;
        src_b = '0;
        @(posedge clk); #1;
        test_reset();
        test_reset_with_start();
        test_multu();
        test_divu();
        test_div_zero();
        test_start_during_run();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle controller that borrows the execute-stage 32-bit ALU to run unsigned multiply (multu) and unsigned divide (divu). It uses iterative shift-add and restoring division, and delivers a 64-bit result in hi/lo. It sits beside the ALU in the execute stage. While it owns the ALU it asserts `alu_sel`, and the execute stage muxes the sequencer's `alu_a`/`alu_b`/`alu_control` onto the ALU inputs. The ALU result returns combinationally in the same cycle.

## Interface
- `WIDTH`, 32, operand width; only 32 is supported.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request an operation; sampled only in IDLE.
- `op` in 1: 0 = multu, 1 = divu; latched with `start`.
- `src_a` in 32: multiplicand or dividend; latched with `start`.
- `src_b` in 32: multiplier or divisor; latched with `start`.
- `alu_result` in 32: ALU output for the current `alu_a`/`alu_b`/`alu_control`.
- `busy` out 1: high in RUN and DONE.
- `done` out 1: one-cycle pulse in DONE.
- `hi` out 32: product[63:32] or remainder.
- `lo` out 32: product[31:0] or quotient.
- `alu_sel` out 1: high only in RUN; the sequencer owns the ALU.
- `alu_a` out 32: ALU operand A.
- `alu_b` out 32: ALU operand B.
- `alu_control` out 3: 3'b010 (add) or 3'b110 (sub).

## Operation
- **States:** IDLE, RUN, DONE.
- **Registers:** `hi`, `lo`, `opnd` (latched `src_a` or `src_b`), `op_r`, and a 6-bit iteration counter.
- **IDLE + start**, latch operands:
  - multu: `hi`=0, `lo`=`src_b`, `opnd`=`src_a`.
  - divu: `hi`=0, `lo`=`src_a`, `opnd`=`src_b`.
  - Counter is cleared; next state is RUN.
- **divu with `src_b`==0:** skip RUN and go straight to DONE with `hi`=`src_a`, `lo`=32'hFFFFFFFF.
- **RUN, multu step:**
  - Drive `alu_a`=`hi`, `alu_b` = `lo[0]` ? `opnd` : 0, `alu_control`=3'b010.
  - `carry` = (`alu_result` < `hi`), unsigned.
  - Update: {`hi`,`lo`} <= {`carry`, `alu_result`, `lo[31:1]`}.
- **RUN, divu step:**
  - `r` = {`hi[30:0]`, `lo[31]`}, `msb` = `hi[31]`.
  - Drive `alu_a`=`r`, `alu_b`=`opnd`, `alu_control`=3'b110.
  - `q` = `msb` | (`r` >= `opnd`).
  - Update: `hi` <= `q` ? `alu_result` : `r`; `lo` <= {`lo[30:0]`, `q`}.
- **RUN length:** exactly 32 steps, counter 0..31. The step with counter==31 transitions to DONE.
- **DONE:** `done`=1 for one cycle; next state is IDLE. `hi`/`lo` hold until the next accepted `start` or `reset`.
- **Outside RUN:** `alu_sel`=0, `alu_a`=0, `alu_b`=0, `alu_control`=3'b010.
- **`start` with `busy`=1:** ignored; no queuing.
- **`src_a`/`src_b`/`op` during RUN:** no effect.
- **Arithmetic:** all unsigned mod 2^32 per ALU op. The 33rd bit comes only from `carry`/`msb` as defined above.

## Timing
- **Reset values:** state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter 0, `alu_sel`=0, `alu_a`=0, `alu_b`=0, `alu_control`=3'b010.
- **Normal operation:** `start` sampled at edge E0.
  - RUN occupies cycles E0..E32, with `busy` and `alu_sel` high.
  - `done`=1 and final `hi`/`lo` are visible in the cycle after edge E32.
  - IDLE is entered after edge E33; latency is 33 cycles from `start` to `done`.
- **Divide-by-zero:** `done` is high in the cycle after E0 (latency 1). `alu_sel` is never asserted.
- **Next operation:** earliest new `start` is accepted at the edge that leaves DONE + 1, i.e. the first IDLE cycle.
- **Reset mid-operation:** at the next edge, return to reset values. Partial results are discarded and `done` is never pulsed.
- **Reset together with start:** reset wins.
- **ALU outputs:** `alu_*` are combinational from state and registers. `alu_result` must settle within the same cycle.

## Test plan
- multu 6 × 7 -> `done` at cycle 33, `hi`=0, `lo`=42; `alu_sel` high exactly 32 cycles.
- multu 0xFFFFFFFF × 0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001 (exercises `carry`).
- divu 100 ÷ 7 -> `lo`=14, `hi`=2; divu 0x80000000 ÷ 3 -> `lo`=0x2AAAAAAA, `hi`=2; divu 0xFFFFFFFF ÷ 0xFFFFFFFF -> `lo`=1, `hi`=0.
- divu 5 ÷ 0 -> `done` 1 cycle after `start`, `hi`=5, `lo`=0xFFFFFFFF, `alu_sel` stays 0.
- `start` pulsed during RUN with new operands -> ignored. The original result is delivered, and exactly one `done` pulse is observed.
- `reset` at RUN step 10 -> next cycle `busy`=0, `hi`=`lo`=0, `alu_sel`=0, no `done`. A following multu 3 × 5 gives `lo`=15.
